// File: rtl/csa_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csa_ctrl_pkg
// Shared definitions for the carry-save accumulator controller:
//   WIDTH        operand / result width (the CSA_Adder8 slice is 8 bits wide)
//   MAX_RESOLVE  upper bound on carry-resolution passes after the last beat
//   state_e      controller states (ACC, RESOLVE, DONE)
//   sat_inc()    saturating increment used by the operand counter
// ---------------------------------------------------------------------------
package csa_ctrl_pkg;

  localparam int WIDTH       = 8;
  localparam int MAX_RESOLVE = 8;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Count up to all-ones and hold there.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/csa_accum_ctrl_csa.sv
// ---------------------------------------------------------------------------
// CSA_Adder8
// One level of 3:2 carry-save compression over 8 bits. Each bit position is
// an independent full adder; no carry ripples between positions.
//   a, b, c  three addends
//   sum      bitwise sum (weight 2^i)
//   carry    raw majority carry (weight 2^(i+1), NOT pre-shifted)
// ---------------------------------------------------------------------------
module CSA_Adder8
  import csa_ctrl_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// csa_accum_ctrl
// Accumulates a message of 8-bit operands in carry-save form (S, C), then
// resolves the pending carries by re-running the same CSA slice with a zero
// third operand until no carry bits remain, and presents the sum.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (ready only while accumulating)
//   in_data, in_last    operand and end-of-message marker
//   out_valid/out_ready result handshake (valid only in DONE)
//   out_data            message sum mod 256
//   out_count           number of operands, saturating at 255
//   out_ovf             true sum reached 256 or more
//
// Represented value is S + {C[6:0],0}. A carry landing in C[7] has weight
// 256; it is recorded in the sticky ovf flag when produced and then dropped.
// ---------------------------------------------------------------------------
module csa_accum_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_count,
  output logic             out_ovf
);

  import csa_ctrl_pkg::*;

  state_e           state_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] count_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] csa_b;
  logic [WIDTH-1:0] csa_c;
  logic [WIDTH-1:0] csa_sum;
  logic [WIDTH-1:0] csa_carry;

  // The stored C[7] is never re-read: its weight left via ovf when produced.
  logic unused_c_msb;
  assign unused_c_msb = c_q[WIDTH-1];

  // Shifting the raw carry aligns it to its true weight; the MSB falls off.
  assign csa_b = {c_q[WIDTH-2:0], 1'b0};
  // Resolution passes reuse the slice with a zero third addend.
  assign csa_c = (state_q == ACC) ? in_data : '0;

  CSA_Adder8 u_csa (
    .a     (s_q),
    .b     (csa_b),
    .c     (csa_c),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // NOTE: every state register here is written with <= so that all of them
  // see the pre-edge values of each other; mixing in = would make the result
  // depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      s_q         <= '0;
      c_q         <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          // in_ready is high throughout ACC, so in_valid alone is an accept.
          if (in_valid) begin
            s_q     <= csa_sum;
            c_q     <= csa_carry;
            count_q <= sat_inc(count_q);
            ovf_q   <= ovf_q | csa_carry[WIDTH-1];
            if (in_last) begin
              state_q    <= RESOLVE;
              in_ready_q <= 1'b0;
            end
          end
        end

        RESOLVE: begin
          // Each pass pushes the lowest pending carry up by at least one bit,
          // so the loop ends within MAX_RESOLVE passes.
          if (c_q[WIDTH-2:0] == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            s_q   <= csa_sum;
            c_q   <= csa_carry;
            ovf_q <= ovf_q | csa_carry[WIDTH-1];
          end
        end

        DONE: begin
          if (out_ready) begin
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            state_q     <= ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= ACC;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = s_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_accum_ctrl
// Self-checking bench. Expected results come from plain integer arithmetic
// over the beats actually accepted: sum mod 256, min(count,255), sum >= 256.
// ---------------------------------------------------------------------------
module tb_csa_accum_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_count;
  logic       out_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int last_lat = 0;
  byte unsigned msg_q[$];

  always #5 clk = ~clk;

  csa_accum_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends msg_q, waits for the result, checks it, optionally holds it for
  // `hold` cycles with out_ready low, and (if do_release) consumes it.
  task automatic run_msg(input string name, input int gap_pct, input int hold,
                         input bit do_release);
    int          idx = 0;
    int          n_acc = 0;
    int          stall = 0;
    int unsigned total = 0;
    int          lat;
    bit          acc;
    logic [7:0]  exp_data;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;

    while (idx < msg_q.size()) begin
      in_valid  = ($urandom_range(99) >= gap_pct);
      in_data   = in_valid ? msg_q[idx] : 8'($urandom);
      in_last   = in_valid ? (idx == msg_q.size() - 1) : 1'($urandom);
      out_ready = 1'($urandom);
      acc = in_valid && in_ready;
      if (!in_ready) stall++;
      if (stall > 50) begin
        check({name, "_in_ready_stuck"}, in_ready, 1);
        do_reset();
        return;
      end
      next_cycle();
      if (acc) begin
        total += msg_q[idx];
        n_acc++;
        idx++;
      end
    end

    exp_data = total[7:0];
    exp_cnt  = (n_acc > 255) ? 8'd255 : n_acc[7:0];
    exp_ovf  = (total >= 256);

    // Accept edge counts as the first edge; stray inputs here must be ignored.
    lat = 1;
    while (!out_valid && lat < 16) begin
      check({name, "_busy_in_ready"}, in_ready, 0);
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'($urandom);
      next_cycle();
      lat++;
    end
    out_ready = 1'b0;
    check({name, "_out_valid"}, out_valid, 1);
    if (!out_valid) begin
      do_reset();
      return;
    end
    last_lat = lat;
    check({name, "_latency_2_to_10"}, (lat >= 2 && lat <= 10), 1);
    check({name, "_data"},  out_data,  exp_data);
    check({name, "_count"}, out_count, exp_cnt);
    check({name, "_ovf"},   out_ovf,   exp_ovf);

    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
      in_last  = 1'($urandom);
      next_cycle();
      check({name, "_hold_valid"},    out_valid, 1);
      check({name, "_hold_in_ready"}, in_ready,  0);
      check({name, "_hold_data"},     out_data,  exp_data);
      check({name, "_hold_count"},    out_count, exp_cnt);
      check({name, "_hold_ovf"},      out_ovf,   exp_ovf);
    end
    idle_inputs();

    if (do_release) begin
      out_ready = 1'b1;
      next_cycle();
      out_ready = 1'b0;
      check({name, "_release_valid"},    out_valid, 0);
      check({name, "_release_in_ready"}, in_ready,  1);
    end
  endtask

  task automatic set_msg2(input byte unsigned a, input byte unsigned b);
    msg_q = {};
    msg_q.push_back(a);
    msg_q.push_back(b);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rst_out_valid"}, out_valid, 0);
    check({name, "_rst_in_ready"},  in_ready,  1);
    check({name, "_rst_out_data"},  out_data,  0);
    check({name, "_rst_out_count"}, out_count, 0);
    check({name, "_rst_out_ovf"},   out_ovf,   0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    out_ready = 1'b0;
    rst_n     = 1'b0;

    // Beats offered while reset is held must not be taken.
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_last  = 1'b1;
    repeat (3) next_cycle();
    check_reset_outputs("reset");
    idle_inputs();
    rst_n = 1'b1;
    next_cycle();
    check_reset_outputs("post_reset");

    // Single beat: result two cycles after accept.
    msg_q = {8'h2A};
    run_msg("single_2a", 0, 0, 1);
    check("single_2a_latency", last_lat, 2);

    // 0x7F + 0x01: carry walks up seven positions -> seven resolve passes.
    set_msg2(8'h7F, 8'h01);
    run_msg("sum_80", 0, 0, 1);
    check("sum_80_resolve_passes", last_lat - 2, 7);

    // 0xFF + 0x01 wraps to zero with overflow.
    set_msg2(8'hFF, 8'h01);
    run_msg("wrap_ff", 0, 0, 1);

    // Held result with 0x55 offered; 0x55 must not leak into the next message.
    msg_q = {8'h31};
    run_msg("hold5", 0, 5, 1);
    msg_q = {8'h10};
    run_msg("after_hold", 0, 0, 1);

    // Reset during RESOLVE.
    in_valid = 1'b1; in_data = 8'h7F; in_last = 1'b0;
    next_cycle();
    in_data = 8'h01; in_last = 1'b1;
    next_cycle();
    idle_inputs();
    next_cycle();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_resolve");
    @(negedge clk);
    rst_n = 1'b1;
    set_msg2(8'h03, 8'h04);
    run_msg("after_rst_resolve", 0, 0, 1);

    // Reset during ACC with a partial message pending.
    in_valid = 1'b1; in_data = 8'hF0; in_last = 1'b0;
    next_cycle();
    next_cycle();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_acc");
    @(negedge clk);
    rst_n = 1'b1;
    msg_q = {8'h01};
    run_msg("after_rst_acc", 0, 0, 1);

    // Reset while a result waits in DONE.
    set_msg2(8'hC0, 8'h80);
    run_msg("pre_rst_done", 0, 2, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    set_msg2(8'h05, 8'h06);
    run_msg("after_rst_done", 0, 0, 1);

    // 300 ones: count saturates, sum wraps to 0x2C with overflow.
    msg_q = {};
    for (int i = 0; i < 300; i++) msg_q.push_back(8'h01);
    run_msg("ones_300", 0, 0, 1);

    // Randomized messages with gaps, stray inputs and random hold times.
    for (int m = 0; m < 30; m++) begin
      int len;
      len = (m % 10 == 9) ? $urandom_range(256, 270) : $urandom_range(1, 24);
      msg_q = {};
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      run_msg($sformatf("rand%0d", m), 30, $urandom_range(0, 3), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
